// File: rtl/frame_buffer_pkg.sv
// Shared definitions for the frame buffer writer and the LCD scan-out path:
// FSM state encoding, pixel packing and byteenable constants.
package frame_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        CLEAR
    } fb_state_t;

    localparam logic [7:0] BE_FULL = 8'hFF;
    localparam logic [7:0] BE_LOW  = 8'h0F;

    // One 24-bit {blue, green, red} pixel occupies one zero-padded 32-bit half-word.
    function automatic logic [31:0] pack_pixel(input logic [23:0] px);
        return {8'h00, px};
    endfunction

endpackage

// File: rtl/frame_buffer_write_port.sv
// Registered Avalon-MM write stage: holds the word under waitrequest,
// advances the word address on acceptance and wraps LAST -> FIRST.
module frame_buffer_write_port
    import frame_buffer_pkg::*;
#(
    parameter logic [28:0] FIRST = '0,
    parameter logic [28:0] LAST  = '0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue,
    input  logic [63:0] word,
    input  logic [7:0]  be,
    input  logic        rewind,
    input  logic        waitrequest,
    output logic [28:0] address,
    output logic [63:0] writedata,
    output logic [7:0]  byteenable,
    output logic        write,
    output logic        accepted,
    output logic        stalled
);

    logic        r_write;
    logic [28:0] r_address;
    logic [63:0] r_writedata;
    logic [7:0]  r_byteenable;
    logic        r_rewind_pend;
    logic [28:0] w_next;
    logic        w_rewind;

    assign w_next    = (r_address == LAST) ? FIRST : r_address + 29'd1;
    assign w_rewind  = rewind || r_rewind_pend;
    assign accepted  = r_write && !waitrequest;
    assign stalled   = r_write && waitrequest;

    assign address    = r_address;
    assign writedata  = r_writedata;
    assign byteenable = r_byteenable;
    assign write      = r_write;

    // Write stage: freeze while stalled; a rewind requested mid-stall is
    // deferred so the address stays stable until the word is accepted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_write       <= 1'b0;
            r_address     <= FIRST;
            r_writedata   <= '0;
            r_byteenable  <= BE_FULL;
            r_rewind_pend <= 1'b0;
        end else if (r_write && waitrequest) begin
            if (rewind)
                r_rewind_pend <= 1'b1;
        end else begin
            if (r_write)
                r_address <= w_rewind ? FIRST : w_next;
            else if (w_rewind)
                r_address <= FIRST;
            r_rewind_pend <= 1'b0;
            r_write       <= issue;
            if (issue) begin
                r_writedata  <= word;
                r_byteenable <= be;
            end
        end
    end

endmodule

// File: rtl/frame_buffer_writer.sv
// Frame buffer writer: packs renderer pixels two per 64-bit word and writes
// them to SDRAM over Avalon-MM; also performs a hardware clear-screen fill.
// Optional debug counters are enabled by defining FRAME_BUFFER_WRITER_STATS_EN.
module frame_buffer_writer
    import frame_buffer_pkg::*;
#(
    parameter int unsigned ADDRESS = 0,
    parameter int unsigned LENGTH  = 0
) (
    input  logic        clock,
    input  logic        reset,
    output logic [28:0] address,
    output logic [7:0]  burstcount,
    input  logic        waitrequest,
    output logic [63:0] writedata,
    output logic [7:0]  byteenable,
    output logic        write,
    output logic        read,
    input  logic        pixel_valid,
    output logic        pixel_ready,
    input  logic [23:0] pixel_data,
    input  logic        pixel_last,
    input  logic        frame_restart,
    input  logic        clear_start,
    input  logic [23:0] clear_color,
    output logic        busy,
    output logic        frame_done
`ifdef FRAME_BUFFER_WRITER_STATS_EN
   ,output logic [31:0] debug_word_count,
    output logic [31:0] debug_stall_count
`endif
);

    localparam logic [28:0] FIRST  = 29'(ADDRESS / 8);
    localparam logic [28:0] LAST   = 29'(ADDRESS / 8 + LENGTH / 8 - 1);
    localparam logic [31:0] NWORDS = 32'(LENGTH / 8);

    fb_state_t   r_state;
    logic        r_half;
    logic [31:0] r_low;
    logic        r_last_pend;
    logic [31:0] r_clr_cnt;
    logic [63:0] r_clear_word;
    logic        r_frame_done;

    logic        w_issue;
    logic [63:0] w_word;
    logic [7:0]  w_be;
    logic        w_rewind;
    logic        w_accepted;
    logic        w_stalled;
    logic        w_pix_acc;
    logic        w_done_stream;
    logic        w_done_clear;
    logic        w_done;

    assign burstcount  = 8'h01;
    assign read        = 1'b0;
    assign busy        = (r_state != IDLE);
    assign frame_done  = r_frame_done;
    assign pixel_ready = ((r_state == IDLE) || (r_state == STREAM)) && !w_stalled;
    assign w_pix_acc   = pixel_valid && pixel_ready;

    assign w_done_stream = (r_state == STREAM) && r_last_pend && w_accepted;
    assign w_done_clear  = (r_state == CLEAR) && (r_clr_cnt == NWORDS) && w_accepted;
    assign w_done        = (w_done_stream || w_done_clear) && !frame_restart;
    assign w_rewind      = frame_restart || w_done_stream || w_done_clear;

    frame_buffer_write_port #(
        .FIRST (FIRST),
        .LAST  (LAST)
    ) u_write_port (
        .clock       (clock),
        .reset       (reset),
        .issue       (w_issue),
        .word        (w_word),
        .be          (w_be),
        .rewind      (w_rewind),
        .waitrequest (waitrequest),
        .address     (address),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .write       (write),
        .accepted    (w_accepted),
        .stalled     (w_stalled)
    );

    // Word issue: clear fill words, completed pixel pairs or a trailing lone pixel.
    always_comb begin
        w_issue = 1'b0;
        w_word  = '0;
        w_be    = BE_FULL;
        if (!frame_restart) begin
            if (r_state == CLEAR) begin
                if (!w_stalled && (r_clr_cnt != NWORDS)) begin
                    w_issue = 1'b1;
                    w_word  = r_clear_word;
                end
            end else if (w_pix_acc && !((r_state == IDLE) && clear_start)) begin
                if (r_half) begin
                    w_issue = 1'b1;
                    w_word  = {pack_pixel(pixel_data), r_low};
                end else if (pixel_last) begin
                    w_issue = 1'b1;
                    w_word  = {32'h0, pack_pixel(pixel_data)};
                    w_be    = BE_LOW;
                end
            end
        end
    end

    // Control FSM: pixel pairing, clear sequencing, frame completion and restart.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_half       <= 1'b0;
            r_low        <= '0;
            r_last_pend  <= 1'b0;
            r_clr_cnt    <= '0;
            r_clear_word <= '0;
            r_frame_done <= 1'b0;
        end else begin
            // A one-pixel frame finishing right after another merges into one
            // pulse so frame_done never stays high for two cycles.
            r_frame_done <= w_done && !r_frame_done;
            if (frame_restart) begin
                r_state     <= IDLE;
                r_half      <= 1'b0;
                r_last_pend <= 1'b0;
                r_clr_cnt   <= '0;
            end else begin
                if (w_done_stream) begin
                    r_last_pend <= 1'b0;
                    r_state     <= IDLE;
                end
                if (w_done_clear)
                    r_state <= IDLE;
                if ((r_state == CLEAR) && w_issue)
                    r_clr_cnt <= r_clr_cnt + 32'd1;
                if ((r_state == IDLE) && clear_start) begin
                    r_state      <= CLEAR;
                    r_clr_cnt    <= '0;
                    r_clear_word <= {pack_pixel(clear_color), pack_pixel(clear_color)};
                end else if (w_pix_acc) begin
                    // The acceptance cycle of a frame's last word may already
                    // take the first pixel of the next frame.
                    r_state <= STREAM;
                    if (r_half) begin
                        r_half <= 1'b0;
                        if (pixel_last)
                            r_last_pend <= 1'b1;
                    end else if (pixel_last) begin
                        r_last_pend <= 1'b1;
                    end else begin
                        r_low  <= pack_pixel(pixel_data);
                        r_half <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef FRAME_BUFFER_WRITER_STATS_EN
    logic [31:0] r_word_cnt;
    logic [31:0] r_stall_cnt;
    logic [31:0] r_dbg_word;
    logic [31:0] r_dbg_stall;
    logic        w_stat_evt;

    assign w_stat_evt        = (w_done && !r_frame_done) || frame_restart;
    assign debug_word_count  = r_dbg_word;
    assign debug_stall_count = r_dbg_stall;

    // Debug counters: snapshot running totals on frame end or restart, then clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_word_cnt  <= '0;
            r_stall_cnt <= '0;
            r_dbg_word  <= '0;
            r_dbg_stall <= '0;
        end else if (w_stat_evt) begin
            r_dbg_word  <= r_word_cnt + {31'd0, w_accepted};
            r_dbg_stall <= r_stall_cnt + {31'd0, w_stalled};
            r_word_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_word_cnt  <= r_word_cnt + {31'd0, w_accepted};
            r_stall_cnt <= r_stall_cnt + {31'd0, w_stalled};
        end
    end
`endif

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Directed self-checking bench for frame_buffer_writer (ADDRESS=0x1000, LENGTH=64).
module tb_frame_buffer_writer;

    logic        clock;
    logic        reset;
    logic [28:0] address;
    logic [7:0]  burstcount;
    logic        waitrequest;
    logic [63:0] writedata;
    logic [7:0]  byteenable;
    logic        write;
    logic        read;
    logic        pixel_valid;
    logic        pixel_ready;
    logic [23:0] pixel_data;
    logic        pixel_last;
    logic        frame_restart;
    logic        clear_start;
    logic [23:0] clear_color;
    logic        busy;
    logic        frame_done;

    int errors = 0;
    int checks = 0;

    logic [28:0] q_addr[$];
    logic [63:0] q_data[$];
    logic [7:0]  q_be[$];
    int          done_cnt = 0;
    int          consec = 0;
    logic        prev_fd = 1'b0;

    frame_buffer_writer #(
        .ADDRESS (32'h1000),
        .LENGTH  (64)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .address       (address),
        .burstcount    (burstcount),
        .waitrequest   (waitrequest),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .write         (write),
        .read          (read),
        .pixel_valid   (pixel_valid),
        .pixel_ready   (pixel_ready),
        .pixel_data    (pixel_data),
        .pixel_last    (pixel_last),
        .frame_restart (frame_restart),
        .clear_start   (clear_start),
        .clear_color   (clear_color),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Bus monitor: records every accepted word and frame_done pulses.
    always @(negedge clock) begin
        if (!reset) begin
            if (write && !waitrequest) begin
                q_addr.push_back(address);
                q_data.push_back(writedata);
                q_be.push_back(byteenable);
            end
            if (frame_done) done_cnt++;
            if (frame_done && prev_fd) consec++;
            prev_fd = frame_done;
        end
    end

    function automatic logic [63:0] pair(input int lo, input int hi);
        logic [23:0] l;
        logic [23:0] h;
        l = 24'(lo);
        h = 24'(hi);
        return {8'h00, h, 8'h00, l};
    endfunction

    task automatic push_pixel(input logic [23:0] d, input logic l);
        bit ok;
        ok = 0;
        pixel_valid = 1'b1;
        pixel_data  = d;
        pixel_last  = l;
        for (int t = 0; t < 50; t++) begin
            @(negedge clock);
            if (pixel_ready === 1'b1) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL push_timeout pixel=%h got ready=%b required 1", d, pixel_ready);
        end
        @(posedge clock); #1;
        pixel_valid = 1'b0;
        pixel_last  = 1'b0;
    endtask

    task automatic pulse_restart();
        frame_restart = 1'b1;
        @(posedge clock); #1;
        frame_restart = 1'b0;
    endtask

    task automatic check_word(input string name, input int idx, input logic [28:0] ea,
                              input logic [63:0] ed, input logic [7:0] eb);
        checks++;
        if (idx >= q_addr.size()) begin
            errors++;
            $display("FAIL %s missing word %0d, got %0d words", name, idx, q_addr.size());
        end else if (q_addr[idx] !== ea || q_data[idx] !== ed || q_be[idx] !== eb) begin
            errors++;
            $display("FAIL %s word %0d got %h/%h/%h required %h/%h/%h", name, idx,
                     q_addr[idx], q_data[idx], q_be[idx], ea, ed, eb);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; waitrequest = 1'b0; pixel_valid = 1'b0; pixel_data = '0;
        pixel_last = 1'b0; frame_restart = 1'b0; clear_start = 1'b0; clear_color = '0;
        repeat (2) @(posedge clock); #1;
        checks++; if (address !== 29'h200) begin errors++; $display("FAIL reset_address got %h required 200", address); end
        checks++; if (write !== 1'b0) begin errors++; $display("FAIL reset_write got %b required 0", write); end
        checks++; if (writedata !== 64'h0) begin errors++; $display("FAIL reset_writedata got %h required 0", writedata); end
        checks++; if (byteenable !== 8'hFF) begin errors++; $display("FAIL reset_byteenable got %h required ff", byteenable); end
        checks++; if (busy !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b%b required 00", busy, frame_done); end
        checks++; if (burstcount !== 8'h01 || read !== 1'b0) begin errors++; $display("FAIL reset_const got %h/%b required 01/0", burstcount, read); end
        checks++; if (pixel_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b required 1", pixel_ready); end
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_stream16();
        int base, d0;
        base = q_addr.size(); d0 = done_cnt;
        for (int i = 1; i <= 16; i++) push_pixel(24'(i), i == 16);
        repeat (6) @(posedge clock); #1;
        checks++; if (q_addr.size() - base != 8) begin errors++; $display("FAIL s16_count got %0d required 8", q_addr.size() - base); end
        check_word("s16_first", base, 29'h200, 64'h00000002_00000001, 8'hFF);
        for (int k = 1; k < 8; k++)
            check_word("s16", base + k, 29'(32'h200 + k), pair(2 * k + 1, 2 * k + 2), 8'hFF);
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL s16_done got %0d required 1", done_cnt - d0); end
        checks++; if (address !== 29'h200 || busy !== 1'b0) begin errors++; $display("FAIL s16_end got %h/%b required 200/0", address, busy); end
    endtask

    task automatic test_three();
        int base, d0;
        base = q_addr.size(); d0 = done_cnt;
        push_pixel(24'd1, 1'b0); push_pixel(24'd2, 1'b0); push_pixel(24'd3, 1'b1);
        repeat (6) @(posedge clock); #1;
        checks++; if (q_addr.size() - base != 2) begin errors++; $display("FAIL three_count got %0d required 2", q_addr.size() - base); end
        check_word("three_pair", base, 29'h200, 64'h00000002_00000001, 8'hFF);
        check_word("three_lone", base + 1, 29'h201, 64'h00000000_00000003, 8'h0F);
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL three_done got %0d required 1", done_cnt - d0); end
    endtask

    task automatic test_stall();
        int base, d0;
        base = q_addr.size(); d0 = done_cnt;
        push_pixel(24'd1, 1'b0);
        waitrequest = 1'b1;
        push_pixel(24'd2, 1'b0);
        pixel_valid = 1'b1; pixel_data = 24'd3; pixel_last = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            checks++; if (write !== 1'b1) begin errors++; $display("FAIL stall_write c%0d got %b required 1", c, write); end
            checks++; if (address !== 29'h200) begin errors++; $display("FAIL stall_addr c%0d got %h required 200", c, address); end
            checks++; if (writedata !== 64'h00000002_00000001) begin errors++; $display("FAIL stall_data c%0d got %h required 0000000200000001", c, writedata); end
            checks++; if (pixel_ready !== 1'b0) begin errors++; $display("FAIL stall_ready c%0d got %b required 0", c, pixel_ready); end
        end
        @(posedge clock); #1;
        waitrequest = 1'b0;
        push_pixel(24'd3, 1'b0); push_pixel(24'd4, 1'b1);
        repeat (6) @(posedge clock); #1;
        checks++; if (q_addr.size() - base != 2) begin errors++; $display("FAIL stall_count got %0d required 2", q_addr.size() - base); end
        check_word("stall_w0", base, 29'h200, 64'h00000002_00000001, 8'hFF);
        check_word("stall_w1", base + 1, 29'h201, 64'h00000004_00000003, 8'hFF);
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL stall_done got %0d required 1", done_cnt - d0); end
    endtask

    task automatic test_clear();
        int base, d0, busy_bad, ready_bad;
        bit seen;
        base = q_addr.size(); d0 = done_cnt; busy_bad = 0; ready_bad = 0; seen = 0;
        clear_color = 24'hFF00FF;
        clear_start = 1'b1;
        @(posedge clock); #1;
        clear_start = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clock);
            if (frame_done === 1'b1) begin seen = 1; break; end
            if (busy !== 1'b1) busy_bad++;
            if (pixel_ready !== 1'b0) ready_bad++;
        end
        repeat (3) @(posedge clock); #1;
        checks++; if (!seen) begin errors++; $display("FAIL clear_timeout got no frame_done required pulse"); end
        checks++; if (busy_bad != 0) begin errors++; $display("FAIL clear_busy got %0d low cycles required 0", busy_bad); end
        checks++; if (ready_bad != 0) begin errors++; $display("FAIL clear_ready got %0d ready cycles required 0", ready_bad); end
        checks++; if (q_addr.size() - base != 8) begin errors++; $display("FAIL clear_count got %0d required 8", q_addr.size() - base); end
        for (int k = 0; k < 8; k++)
            check_word("clear", base + k, 29'(32'h200 + k), 64'h00FF00FF_00FF00FF, 8'hFF);
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL clear_done got %0d required 1", done_cnt - d0); end
        checks++; if (address !== 29'h200 || busy !== 1'b0) begin errors++; $display("FAIL clear_end got %h/%b required 200/0", address, busy); end
    endtask

    task automatic test_restart();
        int base, d0;
        base = q_addr.size(); d0 = done_cnt;
        for (int i = 1; i <= 5; i++) push_pixel(24'(i), 1'b0);
        waitrequest = 1'b1;
        push_pixel(24'd6, 1'b0);
        repeat (2) @(posedge clock); #1;
        pulse_restart();
        @(negedge clock);
        checks++; if (write !== 1'b1 || address !== 29'h202) begin errors++; $display("FAIL rst_hold got %b/%h required 1/202", write, address); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle got %b required 0", busy); end
        repeat (2) @(posedge clock); #1;
        waitrequest = 1'b0;
        repeat (3) @(posedge clock); #1;
        checks++; if (address !== 29'h200) begin errors++; $display("FAIL rst_rewind got %h required 200", address); end
        checks++; if (done_cnt - d0 != 0) begin errors++; $display("FAIL rst_nodone got %0d required 0", done_cnt - d0); end
        push_pixel(24'd9, 1'b0);
        pulse_restart();
        push_pixel(24'd10, 1'b0); push_pixel(24'd11, 1'b1);
        repeat (6) @(posedge clock); #1;
        checks++; if (q_addr.size() - base != 4) begin errors++; $display("FAIL rst_count got %0d required 4", q_addr.size() - base); end
        check_word("rst_w0", base, 29'h200, 64'h00000002_00000001, 8'hFF);
        check_word("rst_w1", base + 1, 29'h201, 64'h00000004_00000003, 8'hFF);
        check_word("rst_stalled", base + 2, 29'h202, 64'h00000006_00000005, 8'hFF);
        check_word("rst_discard", base + 3, 29'h200, 64'h0000000B_0000000A, 8'hFF);
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL rst_done got %0d required 1", done_cnt - d0); end
    endtask

    task automatic test_wrap();
        int base;
        base = q_addr.size();
        for (int i = 1; i <= 18; i++) push_pixel(24'(i), 1'b0);
        repeat (4) @(posedge clock); #1;
        checks++; if (q_addr.size() - base != 9) begin errors++; $display("FAIL wrap_count got %0d required 9", q_addr.size() - base); end
        check_word("wrap_last", base + 7, 29'h207, 64'h00000010_0000000F, 8'hFF);
        check_word("wrap_9th", base + 8, 29'h200, 64'h00000012_00000011, 8'hFF);
        checks++; if (address !== 29'h201 || busy !== 1'b1) begin errors++; $display("FAIL wrap_next got %h/%b required 201/1", address, busy); end
        pulse_restart();
        checks++; if (address !== 29'h200 || busy !== 1'b0) begin errors++; $display("FAIL wrap_restart got %h/%b required 200/0", address, busy); end
    endtask

    task automatic test_reset_midwrite();
        waitrequest = 1'b1;
        push_pixel(24'd1, 1'b0); push_pixel(24'd2, 1'b0);
        @(negedge clock);
        checks++; if (write !== 1'b1 || address !== 29'h200) begin errors++; $display("FAIL mid_pre got %b/%h required 1/200", write, address); end
        #2 reset = 1'b1;
        #1;
        checks++; if (write !== 1'b0 || busy !== 1'b0 || writedata !== 64'h0) begin errors++; $display("FAIL mid_reset got %b/%b/%h required 0/0/0", write, busy, writedata); end
        @(posedge clock); #1;
        waitrequest = 1'b0;
        reset = 1'b0;
        @(posedge clock); #1;
        checks++; if (consec != 0) begin errors++; $display("FAIL done_consec got %0d required 0", consec); end
    endtask

    initial begin
        test_reset();
        test_stream16();
        test_three();
        test_stall();
        test_clear();
        test_restart();
        test_wrap();
        test_reset_midwrite();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
